inst_fetch: RTL

//   Instruction-fetch stage feeding IF_ID and then InstDecode. Holds the PC and

---
 rtl/inst_fetch_pkg.sv | 23 ++
 rtl/inst_fetch_icache_dm.sv | 45 ++++
 rtl/inst_fetch.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared widths, constants and PC helpers for the instruction-fetch slice.
package inst_fetch_pkg;

  localparam int ADDR_LEN = 32;
  localparam int INST_LEN = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [INST_LEN-1:0] ZERO_WORD = '0;

  // Keep bits [addr_w-1:2] of an address; the rest are forced to zero.
  function automatic logic [ADDR_LEN-1:0] pc_mask(input logic [ADDR_LEN-1:0] a,
                                                  input int unsigned addr_w);
    logic [ADDR_LEN-1:0] r;
    r = '0;
    for (int i = 2; i < ADDR_LEN; i++) begin
      if (i < int'(addr_w)) r[i] = a[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/inst_fetch_icache_dm.sv
// Direct-mapped one-word-per-line instruction cache: combinational lookup,
// synchronous fill, valid bits cleared only by reset.
module icache_dm
  import inst_fetch_pkg::*;
#(
  parameter int IDX_W = 7,
  parameter int TAG_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_W-1:0]    rd_idx,
  input  logic [TAG_W-1:0]    rd_tag,
  output logic                hit,
  output logic [INST_LEN-1:0] rd_data,
  input  logic                fill_en,
  input  logic [IDX_W-1:0]    fill_idx,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [INST_LEN-1:0] fill_data
);

  localparam int LINES = 1 << IDX_W;

  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [INST_LEN-1:0] data_mem [LINES];
  logic [LINES-1:0]    valid_reg;

  assign hit     = valid_reg[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_data = data_mem[rd_idx];

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= fill_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
    end else if (fill_en) begin
      valid_reg[fill_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC, direct-mapped I-cache lookup, single-word miss
// handling towards MEMCTRL, stall holding and ID/EX redirects.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                  ADDR_W   = 17,
  parameter int                  IDX_W    = 7,
  parameter logic [ADDR_LEN-1:0] RESET_PC = '0
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                stall_i,
  input  logic                id_jump_i,
  input  logic [ADDR_LEN-1:0] id_jump_pc_i,
  input  logic                ex_jump_i,
  input  logic [ADDR_LEN-1:0] ex_jump_pc_i,
  output logic                mem_req_o,
  output logic [ADDR_LEN-1:0] mem_addr_o,
  input  logic                mem_done_i,
  input  logic [INST_LEN-1:0] mem_inst_i,
  output logic [ADDR_LEN-1:0] pc_o,
  output logic [INST_LEN-1:0] inst_o,
  output logic                inst_valid_o
);

  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e              state_reg, state_next;
  logic [ADDR_LEN-1:0] pc_reg, pc_next;
  logic [ADDR_LEN-1:0] mem_addr_reg, mem_addr_next;
  logic [INST_LEN-1:0] hold_inst_reg, hold_inst_next;
  logic                drop_reg, drop_next;
  logic [ADDR_LEN-1:0] pc_out_reg, pc_out_next;
  logic [INST_LEN-1:0] inst_out_reg, inst_out_next;
  logic                valid_out_reg, valid_out_next;

  logic                cache_hit;
  logic [INST_LEN-1:0] cache_data;
  logic                fill_en;
  logic                redirect;
  logic [ADDR_LEN-1:0] redirect_pc;
  logic [ADDR_LEN-1:0] pc_plus4;

  assign redirect    = ex_jump_i | id_jump_i;
  assign redirect_pc = pc_mask(ex_jump_i ? ex_jump_pc_i : id_jump_pc_i, ADDR_W);
  assign pc_plus4    = pc_mask(pc_reg + ADDR_LEN'(4), ADDR_W);
  // A returned word always fills its line, even when the fetch was dropped.
  assign fill_en     = (state_reg == S_BUSY) && mem_done_i;

  icache_dm #(
    .IDX_W(IDX_W),
    .TAG_W(TAG_W)
  ) u_icache (
    .clk      (clk_in),
    .rst      (rst_in),
    .rd_idx   (pc_reg[IDX_W+1:2]),
    .rd_tag   (pc_reg[ADDR_W-1:IDX_W+2]),
    .hit      (cache_hit),
    .rd_data  (cache_data),
    .fill_en  (fill_en),
    .fill_idx (mem_addr_reg[IDX_W+1:2]),
    .fill_tag (mem_addr_reg[ADDR_W-1:IDX_W+2]),
    .fill_data(mem_inst_i)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg     <= S_IDLE;
      pc_reg        <= pc_mask(RESET_PC, ADDR_W);
      mem_addr_reg  <= '0;
      hold_inst_reg <= ZERO_WORD;
      drop_reg      <= DISABLE;
      pc_out_reg    <= '0;
      inst_out_reg  <= ZERO_WORD;
      valid_out_reg <= DISABLE;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      mem_addr_reg  <= mem_addr_next;
      hold_inst_reg <= hold_inst_next;
      drop_reg      <= drop_next;
      pc_out_reg    <= pc_out_next;
      inst_out_reg  <= inst_out_next;
      valid_out_reg <= valid_out_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    mem_addr_next  = mem_addr_reg;
    hold_inst_next = hold_inst_reg;
    drop_next      = drop_reg;
    pc_out_next    = pc_out_reg;
    inst_out_next  = inst_out_reg;
    valid_out_next = valid_out_reg;

    case (state_reg)
      S_IDLE: begin
        if (redirect) begin
          pc_next        = redirect_pc;
          valid_out_next = DISABLE;
        end else if (cache_hit) begin
          if (!stall_i) begin
            pc_out_next    = pc_reg;
            inst_out_next  = cache_data;
            valid_out_next = ENABLE;
            pc_next        = pc_plus4;
          end
        end else begin
          state_next    = S_BUSY;
          mem_addr_next = pc_reg;
          if (!stall_i) valid_out_next = DISABLE;
        end
      end

      S_BUSY: begin
        if (mem_done_i) begin
          state_next = S_IDLE;
          drop_next  = DISABLE;
          if (redirect) begin
            pc_next        = redirect_pc;
            valid_out_next = DISABLE;
          end else if (drop_reg) begin
            if (!stall_i) valid_out_next = DISABLE;
          end else if (!stall_i) begin
            pc_out_next    = pc_reg;
            inst_out_next  = mem_inst_i;
            valid_out_next = ENABLE;
            pc_next        = pc_plus4;
          end else begin
            hold_inst_next = mem_inst_i;
            state_next     = S_HOLD;
          end
        end else if (redirect) begin
          // The outstanding request cannot be cancelled; its word is discarded on return.
          pc_next        = redirect_pc;
          valid_out_next = DISABLE;
          drop_next      = ENABLE;
        end else if (!stall_i) begin
          valid_out_next = DISABLE;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_next        = redirect_pc;
          valid_out_next = DISABLE;
          state_next     = S_IDLE;
        end else if (!stall_i) begin
          pc_out_next    = pc_reg;
          inst_out_next  = hold_inst_reg;
          valid_out_next = ENABLE;
          pc_next        = pc_plus4;
          state_next     = S_IDLE;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign mem_req_o    = (state_reg == S_BUSY);
  assign mem_addr_o   = mem_addr_reg;
  assign pc_o         = pc_out_reg;
  assign inst_o       = inst_out_reg;
  assign inst_valid_o = valid_out_reg;

endmodule
